// File: rtl/mem_access_ctrl.sv
// Sequencer between a core load/store port and Data_memory: one request at a time,
// with alignment checks, a single-cycle memory strobe and sign/zero-extended load data.
module mem_access_ctrl #(
  parameter int ADDR_W      = 10,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_data_type,
  input  logic [31:0]       mem_data_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic              handshake;
  logic              req_fault;
  logic [31:0]       load_ext;

  // rst also gates req_ready so the core sees no acceptance while reset is held.
  assign req_ready = (state_q == IDLE) && !rst;
  assign handshake = req_valid && req_ready;

  assign req_fault = (req_size == SZ_ILL) ||
                     (CHECK_ALIGN && (((req_size == SZ_HALF) && req_addr[0]) ||
                                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))));

  always_comb begin
    unique case (size_q)
      SZ_BYTE: load_ext = {{24{!uns_q && mem_data_in[7]}}, mem_data_in[7:0]};
      SZ_HALF: load_ext = {{16{!uns_q && mem_data_in[15]}}, mem_data_in[15:0]};
      default: load_ext = mem_data_in;
    endcase
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          rdata_d = '0;
          fault_d = req_fault;
          if (req_fault) begin
            state_d = RESP;
          end else begin
            // Only issued requests update the memory-side registers, so mem_* hold their last access.
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            size_d  = req_size;
            uns_d   = req_unsigned;
            state_d = ISSUE;
          end
        end
      end
      ISSUE:   state_d = we_q ? RESP : WAIT_RD;
      WAIT_RD: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign mem_read       = (state_q == ISSUE) && !we_q;
  assign mem_write      = (state_q == ISSUE) && we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_data_type  = size_q;

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule
